// File: rtl/rz_decode.sv
// Return-to-zero line decoder: classifies high-pulse widths on a WS2812-style line
// into bits and assembles MSB-first 24-bit GRB words, flagging latch gaps and errors.
module rz_decode #(
  parameter int T_THRESH  = 30,
  parameter int HIGH_MIN  = 8,
  parameter int HIGH_MAX  = 60,
  parameter int RESET_CYC = 2500,
  parameter int CNT_W     = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RZ_in,
  output logic [23:0] rx_data,
  output logic        rx_valid,
  output logic        frame_end,
  output logic        rx_err,
  output logic [15:0] pixel_cnt
);

  // state | meaning
  // SYNC  | waiting for a full reset gap before trusting the line
  // IDLE  | between frames, waiting for the first rising edge
  // HIGH  | measuring a high pulse
  // LOW   | measuring the low time after a bit
  typedef enum logic [1:0] {SYNC, IDLE, HIGH, LOW} state_t;

  localparam logic [CNT_W-1:0] C_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_THRESH = CNT_W'(T_THRESH);
  localparam logic [CNT_W-1:0] C_HMIN   = CNT_W'(HIGH_MIN);
  localparam logic [CNT_W-1:0] C_HLAST  = CNT_W'(HIGH_MAX - 1);
  localparam logic [CNT_W-1:0] C_RLAST  = CNT_W'(RESET_CYC - 1);

  state_t           state;
  logic             s1;
  logic             in_s;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [4:0]       bit_idx;
  logic [23:0]      shift;
  logic             bit_val;

  assign cnt_inc = (&cnt) ? cnt : cnt + C_ONE;
  assign bit_val = (cnt >= C_THRESH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1   <= 1'b0;
      in_s <= 1'b0;
    end else begin
      s1   <= RZ_in;
      in_s <= s1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SYNC;
      cnt       <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_end <= 1'b0;
      rx_err    <= 1'b0;
      pixel_cnt <= '0;
    end else begin
      rx_valid  <= 1'b0;
      frame_end <= 1'b0;
      rx_err    <= 1'b0;
      case (state)
        SYNC: begin
          bit_idx <= '0;
          if (in_s) begin
            cnt <= '0;
          end else if (cnt >= C_RLAST) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt_inc;
          end
        end
        IDLE: begin
          bit_idx <= '0;
          if (in_s) begin
            pixel_cnt <= '0;
            cnt       <= C_ONE;
            state     <= HIGH;
          end
        end
        HIGH: begin
          if (in_s) begin
            if (cnt >= C_HLAST) begin
              rx_err  <= 1'b1;
              bit_idx <= '0;
              cnt     <= '0;
              state   <= SYNC;
            end else begin
              cnt <= cnt_inc;
            end
          end else if (cnt < C_HMIN) begin
            rx_err  <= 1'b1;
            bit_idx <= '0;
            cnt     <= '0;
            state   <= SYNC;
          end else begin
            shift <= {shift[22:0], bit_val};
            cnt   <= C_ONE;
            state <= LOW;
            if (bit_idx == 5'd23) begin
              rx_data   <= {shift[22:0], bit_val};
              rx_valid  <= 1'b1;
              pixel_cnt <= pixel_cnt + 16'd1;
              bit_idx   <= '0;
            end else begin
              bit_idx <= bit_idx + 5'd1;
            end
          end
        end
        LOW: begin
          if (in_s) begin
            cnt   <= C_ONE;
            state <= HIGH;
          end else if (cnt >= C_RLAST) begin
            // a latch gap mid-word drops the partial word and flags it
            frame_end <= 1'b1;
            rx_err    <= (bit_idx != 5'd0);
            bit_idx   <= '0;
            cnt       <= '0;
            state     <= IDLE;
          end else begin
            cnt <= cnt_inc;
          end
        end
        default: state <= SYNC;
      endcase
    end
  end

endmodule

// File: tb/tb_rz_decode.sv
// Directed bench for rz_decode: run-length reference model checked every cycle,
// plus literal per-scenario expectations.
module tb_rz_decode;
  localparam int RC = 2500;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rz = 1'b0;
  logic [23:0] rx_data;
  logic        rx_valid;
  logic        frame_end;
  logic        rx_err;
  logic [15:0] pixel_cnt;

  rz_decode dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .RZ_in     (rz),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_end (frame_end),
    .rx_err    (rx_err),
    .pixel_cnt (pixel_cnt)
  );

  always #10 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      if (miscompares <= 30)
        $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model state: line delay, sync/frame flags, run lengths, bit list
  logic        p1, p2, v;
  bit          synced, in_frame;
  int          zrun, hrun, lrun, nbits;
  logic [23:0] acc;
  logic        e_valid, e_fe, e_err;
  logic [23:0] e_data;
  logic [15:0] e_pix;

  task automatic drop_frame();
    synced = 0; in_frame = 0; zrun = 0; nbits = 0; hrun = 0; lrun = 0;
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      p1 = 0; p2 = 0; acc = 0;
      drop_frame();
      e_valid = 0; e_fe = 0; e_err = 0; e_data = 0; e_pix = 0;
    end else begin
      v = p2; p2 = p1; p1 = rz;
      e_valid = 0; e_fe = 0; e_err = 0;
      if (!synced) begin
        zrun = v ? 0 : zrun + 1;
        if (zrun == RC) begin synced = 1; in_frame = 0; end
      end else if (!in_frame) begin
        if (v) begin in_frame = 1; e_pix = 0; hrun = 1; lrun = 0; end
      end else if (v) begin
        if (hrun == 0) begin hrun = 1; lrun = 0; end
        else hrun++;
        if (hrun == 60) begin e_err = 1; drop_frame(); end
      end else if (hrun > 0) begin
        if (hrun < 8) begin
          e_err = 1; drop_frame();
        end else begin
          acc = {acc[22:0], (hrun >= 30)};
          nbits++; hrun = 0; lrun = 1;
          if (nbits == 24) begin e_valid = 1; e_data = acc; e_pix = e_pix + 16'd1; nbits = 0; end
        end
      end else begin
        lrun++;
        if (lrun == RC) begin
          e_fe = 1; e_err = (nbits != 0); nbits = 0; in_frame = 0;
        end
      end
    end
  end

  int n_valid = 0, n_fe = 0, n_err = 0, n_both = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_data", {8'h0, rx_data}, 32'h0);
      chk("rst_valid", {31'h0, rx_valid}, 32'h0);
      chk("rst_fe", {31'h0, frame_end}, 32'h0);
      chk("rst_err", {31'h0, rx_err}, 32'h0);
      chk("rst_pix", {16'h0, pixel_cnt}, 32'h0);
    end else begin
      chk("rx_data", {8'h0, rx_data}, {8'h0, e_data});
      chk("rx_valid", {31'h0, rx_valid}, {31'h0, e_valid});
      chk("frame_end", {31'h0, frame_end}, {31'h0, e_fe});
      chk("rx_err", {31'h0, rx_err}, {31'h0, e_err});
      chk("pixel_cnt", {16'h0, pixel_cnt}, {16'h0, e_pix});
      if (rx_valid === 1'b1) n_valid++;
      if (frame_end === 1'b1) n_fe++;
      if (rx_err === 1'b1) n_err++;
      if (frame_end === 1'b1 && rx_err === 1'b1) n_both++;
    end
  end

  task automatic hold(input logic val, input int n);
    repeat (n) begin
      @(posedge clk);
      #1 rz = val;
    end
  endtask

  task automatic pulse(input int h, input int l);
    hold(1'b1, h);
    hold(1'b0, l);
  endtask

  task automatic send_word(input logic [23:0] w);
    for (int i = 23; i >= 0; i--) begin
      if (w[i]) pulse(40, 22);
      else pulse(20, 42);
    end
  endtask

  int bv, bf, be, bb;

  task automatic snap();
    bv = n_valid; bf = n_fe; be = n_err; bb = n_both;
  endtask

  task automatic lit(input string tag, input int dv, input int df, input int de,
                     input logic [23:0] data, input logic [15:0] pix);
    @(negedge clk);
    chk({tag, "_nvalid"}, 32'(n_valid - bv), 32'(dv));
    chk({tag, "_nfe"}, 32'(n_fe - bf), 32'(df));
    chk({tag, "_nerr"}, 32'(n_err - be), 32'(de));
    chk({tag, "_data"}, {8'h0, rx_data}, {8'h0, data});
    chk({tag, "_pix"}, {16'h0, pixel_cnt}, {16'h0, pix});
  endtask

  initial begin
    rz = 1'b0;
    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b1;

    // single word after sync
    snap();
    hold(1'b0, 3000);
    send_word(24'hAA0000);
    hold(1'b0, 2600);
    lit("one_word", 1, 1, 0, 24'hAA0000, 16'd1);

    // three back-to-back words
    snap();
    send_word(24'hFFFFFF);
    send_word(24'h000000);
    send_word(24'h123456);
    hold(1'b0, 2600);
    lit("three_words", 3, 1, 0, 24'h123456, 16'd3);

    // partial word then latch gap
    snap();
    for (int i = 0; i < 10; i++) pulse(40, 22);
    hold(1'b0, 2600);
    lit("partial", 0, 1, 1, 24'h123456, 16'd0);
    chk("partial_coincident", 32'(n_both - bb), 32'd1);

    // glitch, ignored word, gap, good word
    snap();
    for (int i = 0; i < 5; i++) pulse(20, 42);
    pulse(4, 40);
    send_word(24'hC3C3C3);
    hold(1'b0, 2600);
    send_word(24'h5A3C96);
    hold(1'b0, 2600);
    lit("glitch", 1, 1, 1, 24'h5A3C96, 16'd1);

    // width boundaries 8/29 -> 0, 30/59 -> 1
    snap();
    for (int i = 0; i < 6; i++) begin
      pulse(8, 40); pulse(29, 40); pulse(30, 40); pulse(59, 40);
    end
    hold(1'b0, 2600);
    lit("bounds", 1, 1, 0, 24'h333333, 16'd1);

    // stuck high
    snap();
    hold(1'b1, 100);
    hold(1'b0, 2600);
    lit("stuck", 0, 0, 1, 24'h333333, 16'd0);

    // reset mid-word, then no decode until a gap
    for (int i = 0; i < 12; i++) pulse(40, 22);
    hold(1'b1, 10);
    @(posedge clk);
    #1 begin rst_n = 1'b0; rz = 1'b0; end
    #1;
    chk("rst_mid_data", {8'h0, rx_data}, 32'h0);
    chk("rst_mid_pix", {16'h0, pixel_cnt}, 32'h0);
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b1;
    snap();
    send_word(24'hABCDEF);
    hold(1'b0, 2600);
    lit("after_rst", 0, 0, 0, 24'h000000, 16'd0);
    send_word(24'h0F0F0F);
    hold(1'b0, 2600);
    lit("after_gap", 1, 1, 0, 24'h0F0F0F, 16'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rz_decode.md
# rz_decode

Return-to-zero line decoder and the receive-side counterpart of the RZ_Code transmitter. It samples a WS2812-style single-wire RZ stream at 50 MHz and classifies each high pulse by its width as a 0 or a 1. Bits are assembled MSB-first into 24-bit GRB words. The block flags word completion, frame latch (reset gap) and protocol errors. It is used for loopback checking of the LED driver chain and for chaining boards over the same line.

## Interface
Parameters:
- T_THRESH, 30: high-width threshold in clk cycles; width ≥ T_THRESH decodes as 1, otherwise 0.
- HIGH_MIN, 8: minimum legal high width; shorter is a glitch error.
- HIGH_MAX, 60: high width at which the pulse is declared stuck-high error.
- RESET_CYC, 2500: low time in cycles that constitutes a latch/reset gap (50 µs at 50 MHz).
- CNT_W, 12: width counter bits; must hold RESET_CYC.

Ports:
- clk  in  1  system clock, 50 MHz, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- RZ_in  in  1  asynchronous RZ serial line.
- rx_data  out  24  last complete word, GRB; rx_data[23] = first bit received.
- rx_valid  out  1  one-cycle pulse, rx_data updated this cycle.
- frame_end  out  1  one-cycle pulse on detected reset gap.
- rx_err  out  1  one-cycle pulse on any protocol error.
- pixel_cnt  out  16  complete words received in current frame.

## Operation
- RZ_in passes through a 2-flop synchronizer; the FSM uses only the second stage (in_s).
- Width counter cnt (CNT_W bits) saturates at all-ones. bit_idx runs 0..23. shift is a 24-bit shift register.
- States:
  - SYNC (reset state): counts consecutive in_s=0 cycles; any in_s=1 clears the count. At RESET_CYC goes to IDLE. No frame_end is issued from SYNC. This prevents decoding from mid-stream.
  - IDLE: bit_idx=0. in_s=1 clears pixel_cnt, sets cnt=1 and goes to HIGH.
  - HIGH: cnt++ while in_s=1.
    - cnt reaching HIGH_MAX: rx_err pulse, discard partial word, go to SYNC.
    - in_s=0 with cnt<HIGH_MIN: rx_err pulse, discard partial word, go to SYNC.
    - Otherwise shift in bit (cnt ≥ T_THRESH), cnt=1, go to LOW. If bit_idx was 23: rx_data ← completed word, rx_valid pulse, pixel_cnt++ (wraps 65535→0), bit_idx=0. Else bit_idx++.
  - LOW: cnt++ while in_s=0.
    - in_s=1: cnt=1, go to HIGH. Low width is not otherwise checked.
    - cnt reaching RESET_CYC: frame_end pulse, go to IDLE. If bit_idx≠0, rx_err pulses in the same cycle, the partial word is dropped and bit_idx=0.
- pixel_cnt holds its value through frame_end until the next frame's first rising edge in IDLE.
- rx_data holds its value until the next completed word. It is never changed by errors.

## Timing
- Reset values: rx_data=0, rx_valid=0, frame_end=0, rx_err=0, pixel_cnt=0, cnt=0, bit_idx=0, state=SYNC.
- Reset is asynchronous and clears all state mid-word. After release, the block requires a full RESET_CYC low before accepting bits.
- Latency: rx_valid is high in the cycle following the 3rd rising clk edge after the falling edge of the 24th high pulse on RZ_in.
- Measured cnt equals the RZ_in high width in cycles, ±1 cycle of synchronizer uncertainty.
- rx_valid and frame_end are never coincident. frame_end and rx_err may coincide (partial-word latch).
- All pulse outputs are exactly one cycle wide and registered.
- Nominal input: T0H=20, T1H=40, bit period ≈ 62 cycles. This leaves ≥10 cycles of margin to T_THRESH.

## Test plan
- Reset, 3000 low cycles, then RZ_Code sends 24'hAA0000 with tx_en=1, then 3000 low → one rx_valid with rx_data=24'hAA0000; frame_end ~2500 cycles after the last fall; pixel_cnt=1; rx_err never pulses.
- Three back-to-back words 24'hFFFFFF, 24'h000000, 24'h123456 followed by a gap → three rx_valid pulses with those values in order; pixel_cnt=3 at frame_end.
- 10 valid bits, then 3000 low → frame_end and rx_err in the same cycle; no rx_valid; rx_data unchanged.
- A 4-cycle high glitch within a word → rx_err, state SYNC. The following word is ignored until a 2500-cycle gap occurs, then decodes correctly.
- RZ_in held high 100 cycles → rx_err when cnt hits 60. Separately, rst_n dropped mid-word → all outputs 0 immediately, and the next word is not decoded without a prior gap.
